ysyx_23060096_ifu: RTL
======================

Name: ysyx_23060096_ifu

Overview:
- Instruction fetch unit: holds the PC, issues one instruction-memory request at a time, and presents the fetched 32-bit instruction plus its PC to decode over a valid/ready interface.
- Decode slices the presented instruction into immediate-generator fields (inst[31:7]) and control fields.
- Accepts redirects from branch/jump resolution and discards any in-flight stale fetch.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- XLEN, 32, width of PC and instruction.

Ports:
- clk  in  1  sole clock.
- rstn  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  XLEN  fetch address; equals current PC.
- imem_resp_valid  in  1  response data valid.
- imem_rdata  in  XLEN  fetched instruction.
- redirect_valid  in  1  branch/jump taken; load redirect_pc.
- redirect_pc  in  XLEN  target PC; bits [1:0] forced to 0 internally.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts instruction.
- out_inst  out  XLEN  fetched instruction.
- out_pc  out  XLEN  PC of out_inst.

Behaviour:
- Interface decided: one clock clk; rstn is synchronous, active-high.
- Reset values: pc=RESET_PC, state=REQ, kill=0, out_valid=0, out_inst=0, out_pc=0. imem_req_valid is 1 in the first cycle after reset.
- States:
  - REQ: imem_req_valid=1, imem_addr=pc. On imem_req_ready go to WAIT.
  - WAIT: no request issued. On imem_resp_valid:
    - kill=1: drop data, clear kill, go to REQ.
    - kill=0: out_inst<=imem_rdata, out_pc<=pc, out_valid<=1, pc<=pc+4, go to HOLD.
  - HOLD: out_valid=1, outputs stable. On out_ready: out_valid<=0, go to REQ.
- Redirect (redirect_valid=1) has highest priority and sets pc<=redirect_pc&~3 in every state:
  - REQ without handshake: no kill. The next cycle's imem_addr shows the new PC; memory samples the address only on handshake.
  - REQ with handshake in the same cycle: the accepted request carried the old PC. Set kill=1, go to WAIT.
  - WAIT with no response this cycle: set kill=1, stay in WAIT.
  - WAIT with a response this cycle: drop the response, do not update the outputs, go to REQ with the new PC.
  - HOLD: out_valid<=0 and the held instruction is discarded even if out_ready=1 in that cycle. Go to REQ.
- Exactly one outstanding memory request at a time; responses arriving in REQ or HOLD are ignored.
- PC arithmetic is modulo 2^XLEN: pc=32'hFFFF_FFFC increments to 0.
- Best-case latency with imem_req_ready=1 and a one-cycle response:
  - Request cycle N.
  - Response cycle N+1.
  - out_valid high at N+2.
  - Next request at N+3 after out_ready at N+2.
- Reset asserted mid-operation (any state, kill set or not) returns every register to its reset value in the next cycle. A later stale response is ignored because the state is REQ.
- out_inst and out_pc change only when entering HOLD; they are stable while out_valid=1 and out_ready=0.

Test Plan:
- Basic fetch: release reset, imem_req_ready=1, response one cycle later with rdata=32'h00000013, out_ready=1. Required: imem_addr=0x80000000; then out_valid=1 with out_inst=0x00000013 and out_pc=0x80000000; next request at 0x80000004.
- Backpressure: out_ready=0 for 5 cycles in HOLD. Required: out_valid stays 1, out_inst/out_pc unchanged, imem_req_valid=0; single accept when out_ready rises.
- Redirect during WAIT: redirect_valid with redirect_pc=0x80000100 one cycle before the response carrying 0xDEADBEEF. Required: 0xDEADBEEF never appears on out_valid; next request at 0x80000100.
- Redirect coincident with handshake in REQ: redirect_pc=0x80000203. Required: response dropped, next imem_addr=0x80000200.
- Redirect in HOLD with out_ready=1: required out_valid=0 the next cycle and the held instruction is not counted as accepted; next fetch from the target.
- Mid-operation reset in WAIT with kill=1, followed by a stale response in the cycle after reset: required no out_valid, imem_addr=0x80000000, kill=0.

Source files
------------

// File: rtl/ysyx_23060096_ifu.sv
// Purpose: instruction fetch unit. It holds the PC, issues one imem request at a time and hands {inst, pc} to decode.
// Latency: request in cycle N, response in N+1, out_valid in N+2, next request in N+3 when out_ready is high in N+2.
// Backpressure: HOLD keeps out_inst/out_pc stable until out_ready, and no new request is issued while holding.
//
// Ports:
//   clk, rstn                      clock; synchronous active-high reset
//   imem_req_valid/ready, imem_addr request channel; imem_addr always shows the current PC
//   imem_resp_valid, imem_rdata     response channel; only consumed in WAIT
//   redirect_valid, redirect_pc     branch/jump target; the low two bits are cleared
//   out_valid/ready, out_inst/pc    instruction handed to decode
module ysyx_23060096_ifu #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state;
  state_t          stateNext;
  logic [XLEN-1:0] pc;
  logic            kill;
  logic [XLEN-1:0] instQ;
  logic [XLEN-1:0] instPcQ;

  // A response is kept only if it belongs to the current PC stream.
  // The stream is broken by an earlier redirect (kill) or by a redirect in this same cycle.
  logic takeResp;
  assign takeResp = (state == S_WAIT) && imem_resp_valid && !kill && !redirect_valid;

  // State register and datapath
  always_ff @(posedge clk) begin
    if (rstn) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      kill    <= 1'b0;
      instQ   <= '0;
      instPcQ <= '0;
    end else begin
      state <= stateNext;

      if (redirect_valid)
        pc <= redirect_pc & ~XLEN'(3);
      else if (takeResp)
        pc <= pc + XLEN'(4);

      // kill marks the single outstanding request as stale. That request was
      // accepted with the old PC, or it was still in flight when the redirect arrived.
      if (state == S_REQ && imem_req_ready && redirect_valid)
        kill <= 1'b1;
      else if (state == S_WAIT) begin
        if (imem_resp_valid)
          kill <= 1'b0;
        else if (redirect_valid)
          kill <= 1'b1;
      end

      if (takeResp) begin
        instQ   <= imem_rdata;
        instPcQ <= pc;
      end
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    unique case (state)
      S_REQ: begin
        if (imem_req_ready)
          stateNext = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid)
          stateNext = takeResp ? S_HOLD : S_REQ;
      end
      S_HOLD: begin
        // A redirect drops the held instruction even if decode accepts it in this cycle.
        if (redirect_valid || out_ready)
          stateNext = S_REQ;
      end
      default: stateNext = S_REQ;
    endcase
  end

  // Outputs
  always_comb begin
    imem_req_valid = (state == S_REQ);
    imem_addr      = pc;
    out_valid      = (state == S_HOLD);
    out_inst       = instQ;
    out_pc         = instPcQ;
  end

endmodule
